// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its
// address map: FSM states, output-mux codes and 32-bit Thumb prefixes.
package fetch_pkg;

   localparam int PC_W = 15;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_RUN    = 3'd1,
      ST_BUBBLE = 3'd2,
      ST_HALT   = 3'd3,
      ST_DONE   = 3'd4
   } fetch_state_e;

   localparam logic [1:0] SEL0_BANK0 = 2'd0;
   localparam logic [1:0] SEL0_IR1   = 2'd1;
   localparam logic [1:0] SEL0_BANK1 = 2'd2;

   localparam logic [4:0] PFX32_A = 5'b11101;
   localparam logic [4:0] PFX32_B = 5'b11110;
   localparam logic [4:0] PFX32_C = 5'b11111;

   function automatic logic is_prefix32(input logic [15:0] hw);
      return (hw[15:11] == PFX32_A) || (hw[15:11] == PFX32_B) || (hw[15:11] == PFX32_C);
   endfunction

endpackage

// File: rtl/fetch_addr_map.sv
// Pure combinational map from a halfword PC to the dual-bank ROM row,
// bank-0 row offset and the IR_0/IR_1 output-mux selects.
module fetch_addr_map
   import fetch_pkg::*;
(
   input  logic [PC_W-1:0] pc,
   output logic [PC_W-2:0] rom_addr,
   output logic            pc_1,
   output logic            sel_mem_1,
   output logic [1:0]      sel_mem_0
);

   // Odd PC: IR_0 comes from bank 1 and IR_1 from bank 0 one row further on.
   always_comb begin
      rom_addr = pc[PC_W-1:1];
      pc_1     = pc[0];
      if (pc[0]) begin
         sel_mem_0 = SEL0_BANK1;
         sel_mem_1 = 1'b0;
      end else begin
         sel_mem_0 = SEL0_BANK0;
         sel_mem_1 = 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the halfword PC, tracks decode consumption,
// applies branch redirects with a bubble, and stops on halt or end of program.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC         = 15'd0,
   parameter logic [PC_W-1:0] PROG_LEN         = 15'd46,
   parameter int unsigned     REDIRECT_BUBBLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [15:0]     ir_0,
   input  logic [1:0]      dec_consume,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            halt_req,
   output logic [PC_W-2:0] Rom_addr_in,
   output logic            pc_1,
   output logic            sel_mem_1,
   output logic [1:0]      sel_mem_0,
   output logic            if_valid_0,
   output logic            if_valid_1,
   output logic [PC_W-1:0] if_pc,
   output logic            if_is32,
   output logic            fetch_done,
   output logic            proto_err
);

   localparam logic [1:0] BUBBLES = 2'(REDIRECT_BUBBLES);

   fetch_state_e    state_q, state_d, redirect_state_s;
   logic [PC_W-1:0] pc_q, pc_d, pc_next_s, pc_sum_s;
   logic [1:0]      cnt_q, cnt_d, n_valid_s;
   logic            proto_err_q, proto_err_d;
   logic            fetch_done_q, fetch_done_d;
   logic            v0_s, v1_s, is32_s, bad_consume_s;

   fetch_addr_map u_addr_map (
      .pc        (pc_q),
      .rom_addr  (Rom_addr_in),
      .pc_1      (pc_1),
      .sel_mem_1 (sel_mem_1),
      .sel_mem_0 (sel_mem_0)
   );

   // Valid window and consume legality; 16-bit compare keeps pc+1 from wrapping.
   always_comb begin
      v0_s             = (state_q == ST_RUN) && (pc_q < PROG_LEN);
      v1_s             = (state_q == ST_RUN) && (({1'b0, pc_q} + 16'd1) < {1'b0, PROG_LEN});
      is32_s           = v0_s && is_prefix32(ir_0);
      n_valid_s        = {1'b0, v0_s} + {1'b0, v1_s};
      bad_consume_s    = (dec_consume == 2'd3) || ((dec_consume == 2'd1) && is32_s) ||
                         (dec_consume > n_valid_s);
      pc_sum_s         = pc_q + {13'd0, dec_consume};
      redirect_state_s = (BUBBLES == 2'd0) ? ST_RUN : ST_BUBBLE;
   end

   // Next-state logic for the fetch FSM, PC, bubble counter and flags.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      cnt_d        = cnt_q;
      proto_err_d  = proto_err_q;
      fetch_done_d = 1'b0;
      pc_next_s    = pc_q;
      case (state_q)
         ST_RESET: begin
            if (RESET_PC >= PROG_LEN) begin
               state_d      = ST_DONE;
               fetch_done_d = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (br_taken) begin
               pc_d    = br_target;
               cnt_d   = BUBBLES;
               state_d = redirect_state_s;
            end else begin
               if (bad_consume_s) begin
                  proto_err_d = 1'b1;
                  pc_next_s   = pc_q;
               end else begin
                  pc_next_s = pc_sum_s;
               end
               pc_d = pc_next_s;
               if (halt_req) begin
                  state_d = ST_HALT;
               end else if (pc_next_s >= PROG_LEN) begin
                  state_d      = ST_DONE;
                  fetch_done_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_BUBBLE: begin
            if (br_taken) begin
               pc_d    = br_target;
               cnt_d   = BUBBLES;
               state_d = redirect_state_s;
            end else if (cnt_q <= 2'd1) begin
               cnt_d   = 2'd0;
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_HALT: begin
            if (br_taken) begin
               pc_d = br_target;
            end else begin
               pc_d = pc_q;
            end
            if (!halt_req) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_HALT;
            end
         end
         ST_DONE: begin
            if (br_taken && (br_target < PROG_LEN)) begin
               pc_d    = br_target;
               cnt_d   = BUBBLES;
               state_d = redirect_state_s;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RESET;
         pc_q         <= RESET_PC;
         cnt_q        <= 2'd0;
         proto_err_q  <= 1'b0;
         fetch_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cnt_q        <= cnt_d;
         proto_err_q  <= proto_err_d;
         fetch_done_q <= fetch_done_d;
      end
   end

   assign if_valid_0 = v0_s;
   assign if_valid_1 = v1_s;
   assign if_pc      = pc_q;
   assign if_is32    = is32_s;
   assign fetch_done = fetch_done_q;
   assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table followed by
// randomized traffic against a behavioural fetch model.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam int LEN = 46;
   localparam int BUB = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] ir_0 = 16'd0;
   logic [1:0]  dec_consume = 2'd0;
   logic        br_taken = 1'b0;
   logic [14:0] br_target = 15'd0;
   logic        halt_req = 1'b0;
   logic [13:0] Rom_addr_in;
   logic        pc_1, sel_mem_1, if_valid_0, if_valid_1, if_is32, fetch_done, proto_err;
   logic [1:0]  sel_mem_0;
   logic [14:0] if_pc;

   int n_checks = 0;
   int n_pass = 0;

   fetch_ctrl #(.RESET_PC(15'd0), .PROG_LEN(15'd46), .REDIRECT_BUBBLES(BUB)) dut (
      .clk(clk), .rst_n(rst_n), .ir_0(ir_0), .dec_consume(dec_consume),
      .br_taken(br_taken), .br_target(br_target), .halt_req(halt_req),
      .Rom_addr_in(Rom_addr_in), .pc_1(pc_1), .sel_mem_1(sel_mem_1), .sel_mem_0(sel_mem_0),
      .if_valid_0(if_valid_0), .if_valid_1(if_valid_1), .if_pc(if_pc), .if_is32(if_is32),
      .fetch_done(fetch_done), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      logic [1:0]  cons;
      bit          br;
      logic [14:0] tgt;
      bit          halt;
      logic [15:0] ir0;
      int          e_pc;
      bit          e_v0, e_v1, e_is32, e_done, e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, int cons, bit br, int tgt, bit halt, int ir0,
                               int pc, bit v0, bit v1, bit is32, bit done, bit err);
      vec_t v;
      v.rst = rst; v.cons = 2'(cons); v.br = br; v.tgt = 15'(tgt); v.halt = halt;
      v.ir0 = 16'(ir0); v.e_pc = pc; v.e_v0 = v0; v.e_v1 = v1; v.e_is32 = is32;
      v.e_done = done; v.e_err = err;
      vecs.push_back(v);
   endfunction

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endfunction

   task automatic drive(bit rst, logic [1:0] cons, bit br, logic [14:0] tgt, bit halt, logic [15:0] ir0);
      @(negedge clk);
      rst_n = !rst; dec_consume = cons; br_taken = br; br_target = tgt;
      halt_req = halt; ir_0 = ir0;
      #1;
   endtask

   task automatic check_out(string tag, int e_pc, bit v0, bit v1, bit is32, bit done, bit err);
      chk({tag, "_pc"}, int'(if_pc), e_pc);
      chk({tag, "_rom"}, int'(Rom_addr_in), e_pc / 2);
      chk({tag, "_pc1"}, int'(pc_1), e_pc % 2);
      chk({tag, "_sel0"}, int'(sel_mem_0), (e_pc % 2) * 2);
      chk({tag, "_sel1"}, int'(sel_mem_1), 1 - (e_pc % 2));
      chk({tag, "_sel0_not_ir1"}, int'(sel_mem_0 == SEL0_IR1), 0);
      chk({tag, "_v0"}, int'(if_valid_0), int'(v0));
      chk({tag, "_v1"}, int'(if_valid_1), int'(v1));
      chk({tag, "_is32"}, int'(if_is32), int'(is32));
      chk({tag, "_done"}, int'(fetch_done), int'(done));
      chk({tag, "_err"}, int'(proto_err), int'(err));
   endtask

   // behavioural model state
   int m_pc, m_wait;
   bit m_rst, m_halted, m_ended, m_err, m_pulse;

   initial begin
      // reset, first fetch, single and double consumes to end of program
      add(1, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0);
      add(0, 2, 0, 0, 0, 0,       1, 1, 1, 0, 0, 0);
      for (int p = 3; p <= 43; p += 2) add(0, 2, 0, 0, 0, 0, p, 1, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,       45, 1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       46, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0,       46, 0, 0, 0, 0, 0);
      // redirect with two bubbles, consume on the branch cycle ignored
      add(1, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
      add(0, 2, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0);
      add(0, 2, 0, 0, 0, 0,       2, 1, 1, 0, 0, 0);
      add(0, 2, 1, 10, 0, 0,      4, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       10, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       10, 0, 0, 0, 0, 0);
      add(0, 0, 1, 6, 0, 0,       10, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       6, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       6, 0, 0, 0, 0, 0);
      // 32-bit prefix: half consume is a protocol error, full consume advances
      add(0, 1, 0, 0, 0, 'hF000,  6, 1, 1, 1, 0, 0);
      add(0, 2, 0, 0, 0, 'hF000,  6, 1, 1, 1, 0, 1);
      add(0, 2, 0, 0, 0, 0,       8, 1, 1, 0, 0, 1);
      add(0, 2, 0, 0, 0, 0,       10, 1, 1, 0, 0, 1);
      // halt for three cycles, resume, then reset mid-halt
      add(0, 1, 0, 0, 1, 0,       12, 1, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0,       13, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0,       13, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,       13, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0,       13, 1, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0,       13, 0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 1, 0,       0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].cons, vecs[i].br, vecs[i].tgt, vecs[i].halt, vecs[i].ir0);
         check_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_v0, vecs[i].e_v1,
                   vecs[i].e_is32, vecs[i].e_done, vecs[i].e_err);
      end

      for (int i = 0; i < 3000; i++) begin
         bit          do_rst, br, halt, running, v0, v1, is32, bad;
         int          r, cons, avail;
         logic [14:0] tgt;
         logic [15:0] ir0;
         do_rst = (i == 0) || ($urandom_range(0, 499) == 0);
         r = $urandom_range(0, 99);
         cons = (r < 40) ? 1 : (r < 85) ? 2 : (r < 97) ? 0 : 3;
         br = ($urandom_range(0, 11) == 0);
         tgt = 15'($urandom_range(0, 63));
         halt = ($urandom_range(0, 9) == 0);
         ir0 = 16'($urandom);
         if ($urandom_range(0, 2) == 0) ir0[15:11] = 5'(29 + $urandom_range(0, 2));
         drive(do_rst, 2'(cons), br, tgt, halt, ir0);
         if (do_rst) begin
            m_pc = 0; m_wait = 0; m_rst = 1; m_halted = 0; m_ended = 0; m_err = 0; m_pulse = 0;
         end
         running = !m_rst && (m_wait == 0) && !m_halted && !m_ended;
         v0 = running && (m_pc < LEN);
         v1 = running && (m_pc + 1 < LEN);
         is32 = v0 && ((int'(ir0) >> 11) >= 29);
         check_out($sformatf("rnd%0d", i), m_pc, v0, v1, is32, m_pulse, m_err);
         if (!do_rst) begin
            m_pulse = 0;
            if (m_rst) begin
               m_rst = 0;
               if (m_pc >= LEN) begin m_ended = 1; m_pulse = 1; end
            end else if (m_ended) begin
               if (br && tgt < LEN) begin m_pc = tgt; m_wait = BUB; m_ended = 0; end
            end else if (m_wait > 0) begin
               if (br) begin m_pc = tgt; m_wait = BUB; end
               else m_wait--;
            end else if (m_halted) begin
               if (br) m_pc = tgt;
               if (!halt) m_halted = 0;
            end else if (br) begin
               m_pc = tgt; m_wait = BUB;
            end else begin
               avail = int'(v0) + int'(v1);
               bad = (cons == 3) || (cons == 1 && is32) || (cons > avail);
               if (bad) m_err = 1;
               else m_pc = (m_pc + cons) % 32768;
               if (halt) m_halted = 1;
               else if (m_pc >= LEN) begin m_ended = 1; m_pulse = 1; end
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
